// File: rtl/memory_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_map_pkg
//  Description : Address map constants and bus FSM state encoding shared by
//                memory_bus and its RAM.
//  Contents    : RAM_BASE, ROM_BASE, REGION_MASK, PORT0_ADDR, PORTIN_ADDR,
//                bus_state_t (IDLE / ACCESS / DONE)
//  Revision    : 1.0  initial release
// ============================================================================
package memory_map_pkg;

    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] ROM_BASE    = 16'h4000;
    localparam logic [15:0] REGION_MASK = 16'hFFC0;   // 64-byte windows
    localparam logic [15:0] PORT0_ADDR  = 16'h8008;
    localparam logic [15:0] PORTIN_ADDR = 16'h8009;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
//  Module      : ram
//  Description : Single-port synchronous RAM, DEPTH x 8, write-first,
//                one-cycle read latency. Contents are not reset.
//  Ports       : clk      - clock
//                write_en - write strobe
//                addr     - byte index
//                wdata    - write data
//                rdata    - registered read data (new data on a write)
//  Revision    : 1.0  initial release
// ============================================================================
module ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    import memory_map_pkg::*;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_bus.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bus
//  Description : Fixed-latency request/ready memory bus for the 8008 core.
//                Decodes RAM, ROM window, output port and input port.
//                Optional build macro: MEMORY_BUS_ERROR_EN (enables bus_error
//                pulses for unmapped accesses and writes to read-only space).
//  Ports       : clk, reset (sync, active-low)
//                address/data_in/bus_enable/write_enable - core request
//                data_out/data_ready/busy                - core response
//                rom_address/rom_data                    - program ROM
//                ioport_0 (LED register), ioport_in (button pins)
//                bus_error                               - error pulse
//  Revision    : 1.0  initial release
// ============================================================================
module memory_bus #(
    parameter int         RAM_DEPTH   = 64,
    parameter logic [7:0] RESET_PORT0 = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    input  logic        bus_enable,
    input  logic        write_enable,
    output logic [7:0]  data_out,
    output logic        data_ready,
    output logic        busy,
    output logic [5:0]  rom_address,
    input  logic [7:0]  rom_data,
    output logic [7:0]  ioport_0,
    input  logic [7:0]  ioport_in,
    output logic        bus_error
);
    import memory_map_pkg::*;

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    bus_state_t  state, next_state;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;

    logic        hit_ram, hit_rom, hit_p0, hit_pin;
    logic [7:0]  read_value;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic        ram_we;

    // Decode on the latched address only.
    assign hit_ram = (addr_q & REGION_MASK) == RAM_BASE;
    assign hit_rom = (addr_q & REGION_MASK) == ROM_BASE;
    assign hit_p0  = addr_q == PORT0_ADDR;
    assign hit_pin = addr_q == PORTIN_ADDR;

    assign rom_address = addr_q[5:0];

    // The RAM read is launched from the live address on the accepting edge so
    // the data is already registered during ACCESS and can be captured into
    // data_out at the same edge as the other targets. The write uses the
    // latched address and is suppressed while reset is asserted, so a write
    // caught by reset in ACCESS never lands.
    assign ram_addr = (state == IDLE) ? address[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
    assign ram_we   = (state == ACCESS) && we_q && hit_ram && reset;

    ram #(.DEPTH(RAM_DEPTH), .ADDR_W(RAM_AW)) u_ram (
        .clk      (clk),
        .write_en (ram_we),
        .addr     (ram_addr),
        .wdata    (wdata_q),
        .rdata    (ram_rdata)
    );

    always_comb begin
        read_value = 8'h00;
        if (hit_ram)      read_value = ram_rdata;
        else if (hit_rom) read_value = rom_data;
        else if (hit_p0)  read_value = ioport_0;
        else if (hit_pin) read_value = ioport_in;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus_enable) next_state = ACCESS;
            ACCESS:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            data_out   <= 8'h00;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            ioport_0   <= RESET_PORT0;
        end else begin
            state      <= next_state;
            data_ready <= (next_state == DONE);
            busy       <= (next_state != IDLE);
            if (state == IDLE && bus_enable) begin
                addr_q  <= address;
                wdata_q <= data_in;
                we_q    <= write_enable;
            end
            if (state == ACCESS) begin
                if (we_q) begin
                    data_out <= 8'h00;
                    if (hit_p0) ioport_0 <= wdata_q;
                end else begin
                    data_out <= read_value;
                end
            end
        end
    end

`ifdef MEMORY_BUS_ERROR_EN
    logic access_error;

    assign access_error = !(hit_ram || hit_rom || hit_p0 || hit_pin)
                        || (we_q && (hit_rom || hit_pin));

    // Registered in ACCESS so it lines up with the data_ready pulse in DONE.
    always_ff @(posedge clk) begin
        if (!reset) bus_error <= 1'b0;
        else        bus_error <= (state == ACCESS) && access_error;
    end
`else
    assign bus_error = 1'b0;
`endif

endmodule
`default_nettype wire
